// File: rtl/kmac_msg_rx.sv
// kmac_msg_rx: KMAC-side receiver for the key manager message stream.
// Accepts request beats under a ready handshake and checks that each beat's
// byte strobe is legal. Legal beats go into a small FIFO with the strobe
// expanded to a per-bit mask. Illegal beats are dropped, the FIFO is flushed
// and a sticky error is raised.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   kmac_data_i  request beat, packed as {valid, data[MsgWidth], strb[StrbWidth], last}
//   kmac_ready_o beat accepted when valid && kmac_ready_o
//   msg_valid_o  FIFO head valid
//   msg_data_o   head data (zero when no head)
//   msg_mask_o   head bit mask, byte i = {8{strb[i]}}
//   msg_last_o   head is the last beat of the message
//   msg_ready_i  consumer pops the head when msg_valid_o && msg_ready_i
//   done_o       one-cycle pulse when the last beat is popped
//   err_o        sticky protocol error
//   err_clr_i    clears err_o and returns to idle (only honoured while in error)
//   byte_cnt_o   bytes accepted in the current message (saturating)
module kmac_msg_rx #(
   parameter int MsgWidth  = 64,
   parameter int StrbWidth = MsgWidth / 8,
   parameter int FifoDepth = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [MsgWidth+StrbWidth+1:0]     kmac_data_i,
   output logic                              kmac_ready_o,
   output logic                              msg_valid_o,
   output logic [MsgWidth-1:0]               msg_data_o,
   output logic [MsgWidth-1:0]               msg_mask_o,
   output logic                              msg_last_o,
   input  logic                              msg_ready_i,
   output logic                              done_o,
   output logic                              err_o,
   input  logic                              err_clr_i,
   output logic [15:0]                       byte_cnt_o
);

   localparam int ReqW = MsgWidth + StrbWidth + 2;
   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW = PtrW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MSG   = 2'd1,
      FLUSH = 2'd2,
      ERROR = 2'd3
   } state_t;

   function automatic logic [MsgWidth-1:0] expand_strb(input logic [StrbWidth-1:0] s);
      logic [MsgWidth-1:0] m;
      m = '0;
      for (int i = 0; i < StrbWidth; i++) begin
         m[8*i +: 8] = {8{s[i]}};
      end
      return m;
   endfunction

   function automatic logic [15:0] popcount(input logic [StrbWidth-1:0] s);
      logic [15:0] n;
      n = '0;
      for (int i = 0; i < StrbWidth; i++) begin
         n = n + 16'(s[i]);
      end
      return n;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // Strobe must be non-empty and a run of ones from bit 0; a partial strobe
   // is only allowed on the final beat of a message.
   function automatic logic strb_legal(input logic [StrbWidth-1:0] s, input logic l);
      logic [StrbWidth-1:0] inc;
      inc = s + {{(StrbWidth-1){1'b0}}, 1'b1};
      return (s != '0) && ((s & inc) == '0) && ((&s) || l);
   endfunction

   logic                 req_valid;
   logic [MsgWidth-1:0]  req_data;
   logic [StrbWidth-1:0] req_strb;
   logic                 req_last;

   assign req_valid = kmac_data_i[ReqW-1];
   assign req_data  = kmac_data_i[ReqW-2 -: MsgWidth];
   assign req_strb  = kmac_data_i[StrbWidth:1];
   assign req_last  = kmac_data_i[0];

   state_t               state, state_next;
   logic [CntW-1:0]      count;
   logic [PtrW-1:0]      wr_ptr, rd_ptr;
   logic [15:0]          byte_cnt;

   logic [MsgWidth-1:0]  mem_data [FifoDepth];
   logic [StrbWidth-1:0] mem_strb [FifoDepth];
   logic                 mem_last [FifoDepth];

   logic accept, legal, push, flush, pop, head_last;

   // Ready looks only at the registered count, so a full FIFO holds ready low
   // even in a cycle where the head is being popped.
   assign kmac_ready_o = !rst_i && ((state == IDLE) || (state == MSG)) &&
                         (count < CntW'(FifoDepth));

   assign accept = req_valid && kmac_ready_o;
   assign legal  = strb_legal(req_strb, req_last);
   assign push   = accept && legal;
   assign flush  = accept && !legal;

   assign head_last   = mem_last[rd_ptr];
   assign msg_valid_o = (count != '0) && (state != ERROR);
   assign pop         = msg_valid_o && msg_ready_i;

   // Head fields are gated so the storage itself needs no reset.
   assign msg_data_o = msg_valid_o ? mem_data[rd_ptr] : '0;
   assign msg_mask_o = msg_valid_o ? expand_strb(mem_strb[rd_ptr]) : '0;
   assign msg_last_o = msg_valid_o && head_last;

   assign err_o      = (state == ERROR);
   assign byte_cnt_o = byte_cnt;

   always_comb begin
      state_next = state;
      done_o     = 1'b0;
      case (state)
         IDLE, MSG: begin
            if (accept) begin
               if (!legal)        state_next = ERROR;
               else if (req_last) state_next = FLUSH;
               else               state_next = MSG;
            end
         end
         FLUSH: begin
            if (pop && head_last) begin
               done_o     = 1'b1;
               state_next = IDLE;
            end
         end
         ERROR: begin
            if (err_clr_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         byte_cnt <= '0;
      end else begin
         state <= state_next;

         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            if (push && !pop)      count <= count + CntW'(1);
            else if (!push && pop) count <= count - CntW'(1);
         end

         if ((state == ERROR) && err_clr_i) begin
            byte_cnt <= '0;
         end else if (accept) begin
            byte_cnt <= (state == MSG) ? sat_add16(byte_cnt, popcount(req_strb))
                                       : popcount(req_strb);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data[wr_ptr] <= req_data;
         mem_strb[wr_ptr] <= req_strb;
         mem_last[wr_ptr] <= req_last;
      end
   end

endmodule

// File: tb/tb_kmac_msg_rx.sv
// Testbench for kmac_msg_rx: directed scenarios plus randomized legal
// messages, checked against a queue-based reference model.
module tb_kmac_msg_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        kvalid;
   logic [63:0] kdata;
   logic [7:0]  kstrb;
   logic        klast;
   logic        kmac_ready_o;
   logic        msg_valid_o;
   logic [63:0] msg_data_o;
   logic [63:0] msg_mask_o;
   logic        msg_last_o;
   logic        msg_ready_i;
   logic        done_o;
   logic        err_o;
   logic        err_clr_i;
   logic [15:0] byte_cnt_o;

   always #5 clk = ~clk;

   kmac_msg_rx #(.MsgWidth(64), .StrbWidth(8), .FifoDepth(2)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .kmac_data_i  ({kvalid, kdata, kstrb, klast}),
      .kmac_ready_o (kmac_ready_o),
      .msg_valid_o  (msg_valid_o),
      .msg_data_o   (msg_data_o),
      .msg_mask_o   (msg_mask_o),
      .msg_last_o   (msg_last_o),
      .msg_ready_i  (msg_ready_i),
      .done_o       (done_o),
      .err_o        (err_o),
      .err_clr_i    (err_clr_i),
      .byte_cnt_o   (byte_cnt_o)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  s;
      logic        l;
   } beat_t;

   beat_t expq[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    done_cnt = 0;
   int    exp_bc   = 0;
   bit    in_msg   = 0;
   bit    rand_rdy = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask_of(input logic [7:0] s);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic int ones(input logic [7:0] s);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(s[i]);
      return n;
   endfunction

   // Legal strobe = the n lowest bytes for some n >= 1, full unless last.
   function automatic bit is_legal(input logic [7:0] s, input logic l);
      logic [7:0] all_ones;
      int n;
      all_ones = 8'hFF;
      n = ones(s);
      return (n > 0) && (s == (all_ones >> (8 - n))) && ((n == 8) || l);
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // Pop monitor: every popped head must match the model queue front.
   always @(negedge clk) begin
      beat_t b;
      if (msg_valid_o === 1'b1 && msg_ready_i === 1'b1 && rst === 1'b0) begin
         if (expq.size() == 0) begin
            chk("pop_unexpected", msg_valid_o, 1'b0);
         end else begin
            b = expq.pop_front();
            chk("pop_data", msg_data_o, b.d);
            chk("pop_mask", msg_mask_o, mask_of(b.s));
            chk("pop_last", msg_last_o, b.l);
            chk("pop_done", done_o, b.l);
         end
      end else if (done_o === 1'b1) begin
         chk("done_without_pop", done_o, 1'b0);
      end
      if (done_o === 1'b1) done_cnt++;
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [63:0] d, input logic [7:0] s, input logic l);
      int  waited;
      bit  ok;
      int  n;
      waited = 0;
      ok = 1;
      kvalid = 1'b1; kdata = d; kstrb = s; klast = l;
      forever begin
         @(negedge clk);
         if (kmac_ready_o === 1'b1) break;
         waited++;
         if (waited > 100) begin
            chk("ready_wait", kmac_ready_o, 1'b1);
            ok = 0;
            break;
         end
         @(posedge clk); #1;
         if (rand_rdy) msg_ready_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      kvalid = 1'b0;
      if (ok) begin
         n = ones(s);
         exp_bc = in_msg ? sat16(exp_bc + n) : n;
         if (is_legal(s, l)) begin
            expq.push_back('{d: d, s: s, l: l});
            in_msg = !l;
         end else begin
            expq.delete();
            in_msg = 0;
         end
      end
      if (rand_rdy) msg_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input int prev);
      int cyc;
      cyc = 0;
      while (done_cnt == prev && cyc < 200) begin
         @(posedge clk); #1;
         if (rand_rdy) msg_ready_i = 1'($urandom_range(0, 1));
         cyc++;
      end
      chk("done_wait", done_cnt, prev + 1);
   endtask

   task automatic clear_err();
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      exp_bc = 0;
      @(negedge clk);
      chk("clr_err", err_o, 1'b0);
      chk("clr_ready", kmac_ready_o, 1'b1);
      chk("clr_bytecnt", byte_cnt_o, 16'(exp_bc));
      @(posedge clk); #1;
   endtask

   initial begin
      int prev;
      int len;
      logic [7:0] all_ones;
      logic [7:0] s;
      logic [63:0] d;
      all_ones = 8'hFF;
      rst = 1'b1; kvalid = 1'b0; kdata = '0; kstrb = '0; klast = 1'b0;
      msg_ready_i = 1'b1; err_clr_i = 1'b0;

      // reset
      #1;
      chk("rst_ready_low", kmac_ready_o, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", kmac_ready_o, 1'b1);
      chk("rst_valid", msg_valid_o, 1'b0);
      chk("rst_data", msg_data_o, 64'h0);
      chk("rst_mask", msg_mask_o, 64'h0);
      chk("rst_last", msg_last_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_bytecnt", byte_cnt_o, 16'h0);
      @(posedge clk); #1;

      // single partial last beat
      prev = done_cnt;
      send(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1);
      @(negedge clk);
      chk("t1_valid", msg_valid_o, 1'b1);
      chk("t1_data", msg_data_o, 64'h0123_4567_89AB_CDEF);
      chk("t1_mask", msg_mask_o, 64'h0000_0000_FFFF_FFFF);
      chk("t1_ready_flush", kmac_ready_o, 1'b0);
      chk("t1_bytecnt", byte_cnt_o, 16'(exp_bc));
      @(posedge clk); #1;
      chk("t1_done_cnt", done_cnt, prev + 1);
      @(negedge clk);
      chk("t1_ready_idle", kmac_ready_o, 1'b1);
      chk("t1_valid_after", msg_valid_o, 1'b0);
      chk("t1_bytecnt_hold", byte_cnt_o, 16'd4);
      @(posedge clk); #1;

      // three beats with consumer stalled, FIFO fills
      prev = done_cnt;
      msg_ready_i = 1'b0;
      send({$urandom, $urandom}, 8'hFF, 1'b0);
      send({$urandom, $urandom}, 8'hFF, 1'b0);
      @(negedge clk);
      chk("t2_full_ready", kmac_ready_o, 1'b0);
      chk("t2_full_valid", msg_valid_o, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_still_full", kmac_ready_o, 1'b0);
      @(posedge clk); #1;
      msg_ready_i = 1'b1;
      send({$urandom, $urandom}, 8'h03, 1'b1);
      wait_done(prev);
      chk("t2_bytecnt", byte_cnt_o, 16'd18);
      chk("t2_bytecnt_model", byte_cnt_o, 16'(exp_bc));
      repeat (2) @(posedge clk);
      #1 chk("t2_single_done", done_cnt, prev + 1);

      // non-last partial beat is illegal
      send({$urandom, $urandom}, 8'h7F, 1'b0);
      @(negedge clk);
      chk("t3_err", err_o, 1'b1);
      chk("t3_valid", msg_valid_o, 1'b0);
      chk("t3_ready", kmac_ready_o, 1'b0);
      chk("t3_bytecnt", byte_cnt_o, 16'(exp_bc));
      @(posedge clk); #1;
      clear_err();

      // non-contiguous and empty strobes
      prev = done_cnt;
      send({$urandom, $urandom}, 8'h05, 1'b1);
      @(negedge clk);
      chk("t4_err_noncontig", err_o, 1'b1);
      chk("t4_valid_noncontig", msg_valid_o, 1'b0);
      @(posedge clk); #1;
      clear_err();
      send({$urandom, $urandom}, 8'h00, 1'b1);
      @(negedge clk);
      chk("t4_err_zero", err_o, 1'b1);
      chk("t4_bytecnt_zero", byte_cnt_o, 16'(exp_bc));
      @(posedge clk); #1;
      clear_err();
      chk("t4_no_done", done_cnt, prev);

      // illegal beat while a legal one is buffered
      prev = done_cnt;
      msg_ready_i = 1'b0;
      send({$urandom, $urandom}, 8'hFF, 1'b0);
      @(negedge clk);
      chk("t5_buffered", msg_valid_o, 1'b1);
      @(posedge clk); #1;
      send({$urandom, $urandom}, 8'h7F, 1'b0);
      @(negedge clk);
      chk("t5_flushed", msg_valid_o, 1'b0);
      chk("t5_err", err_o, 1'b1);
      @(posedge clk); #1;
      msg_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t5_still_empty", msg_valid_o, 1'b0);
      @(posedge clk); #1;
      clear_err();
      chk("t5_no_done", done_cnt, prev);

      // reset mid-message
      prev = done_cnt;
      msg_ready_i = 1'b0;
      send({$urandom, $urandom}, 8'hFF, 1'b0);
      send({$urandom, $urandom}, 8'hFF, 1'b0);
      rst = 1'b1;
      expq.delete(); in_msg = 0; exp_bc = 0;
      #1;
      chk("t6_ready", kmac_ready_o, 1'b0);
      chk("t6_valid", msg_valid_o, 1'b0);
      chk("t6_data", msg_data_o, 64'h0);
      chk("t6_mask", msg_mask_o, 64'h0);
      chk("t6_last", msg_last_o, 1'b0);
      chk("t6_err", err_o, 1'b0);
      chk("t6_bytecnt", byte_cnt_o, 16'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      msg_ready_i = 1'b1;
      chk("t6_no_done", done_cnt, prev);
      send({$urandom, $urandom}, 8'hFF, 1'b1);
      wait_done(prev);
      chk("t6_bytecnt_after", byte_cnt_o, 16'd8);

      // randomized legal messages with a random consumer
      rand_rdy = 1;
      for (int m = 0; m < 12; m++) begin
         prev = done_cnt;
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            d = {$urandom, $urandom};
            s = (b == len - 1) ? (all_ones >> $urandom_range(0, 7)) : 8'hFF;
            send(d, s, 1'(b == len - 1));
         end
         wait_done(prev);
         chk("rnd_bytecnt", byte_cnt_o, 16'(exp_bc));
      end
      rand_rdy = 0;
      msg_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("end_idle_ready", kmac_ready_o, 1'b1);
      chk("end_empty", msg_valid_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kmac_msg_rx.md
Name: kmac_msg_rx

Overview:
- KMAC-side receiver for the key manager's `kmac_data_req_t` message stream (`valid`, `data`, `strb`, `last`).
- Accepts beats with a ready handshake and validates strobe legality.
- Expands the per-byte strobe into a per-bit message mask and buffers beats in a small FIFO toward the KMAC message engine.
- Signals message completion with a `done_o` pulse and protocol violations with a sticky `err_o`.

Parameters:
- MsgWidth, 64, message data/mask width in bits; must equal keymgr_pkg::KmacDataIfWidth.
- StrbWidth, MsgWidth/8, byte strobe width.
- FifoDepth, 2, buffered beats (power of two, >=2).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- kmac_data_i  input  $bits(keymgr_pkg::kmac_data_req_t)  request beat from keymgr (valid/data/strb/last)
- kmac_ready_o  output  1  beat accepted when kmac_data_i.valid && kmac_ready_o
- msg_valid_o  output  1  FIFO head valid
- msg_data_o  output  MsgWidth  head data
- msg_mask_o  output  MsgWidth  head bit mask; bits [8*i+:8] = {8{strb[i]}}
- msg_last_o  output  1  head is last beat of message
- msg_ready_i  input  1  consumer pops head when msg_valid_o && msg_ready_i
- done_o  output  1  one-cycle pulse when last beat popped
- err_o  output  1  sticky protocol error
- err_clr_i  input  1  clears err_o, returns to Idle
- byte_cnt_o  output  16  bytes accepted in current message

Behaviour:
- Reset: state=Idle, FIFO empty, kmac_ready_o=0 during reset then 1, msg_valid_o=0, msg_data_o/msg_mask_o/msg_last_o=0, done_o=0, err_o=0, byte_cnt_o=0.
- States: Idle, Msg, Flush, Error.
- kmac_ready_o = (state in {Idle, Msg}) && (fifo count < FifoDepth).
  - Registered count only; no pop-to-push combinational path, so a full FIFO deasserts ready even when the head pops that cycle.
- Legality check on each accepted beat:
  - strb == 0 → illegal.
  - strb non-contiguous from bit 0 (strb & (strb+1)) != 0 → illegal.
  - strb != all-ones && !last → illegal.
- Illegal beat:
  - Dropped, not pushed.
  - FIFO flushed the next cycle.
  - state ← Error; err_o ← 1.
- Legal beat:
  - Pushed as {data, mask-expanded strb, last}.
  - Visible on msg_valid_o the next cycle when the FIFO was empty (1-cycle latency).
- byte_cnt_o:
  - On accept in Idle: loads popcount(strb).
  - On accept in Msg: adds popcount(strb), saturating at 16'hFFFF.
  - Holds value after done.
- Transitions:
  - Idle, legal non-last accept → Msg.
  - Idle or Msg, legal last accept → Flush.
  - Msg, legal non-last accept → stays in Msg.
  - Flush: kmac_ready_o=0. On pop of a head with msg_last_o=1: done_o=1 for that cycle, state → Idle.
  - Any state, illegal accept → Error (also overrides a last beat).
  - Error: kmac_ready_o=0, msg_valid_o=0. err_clr_i=1 → err_o=0, byte_cnt_o=0, state → Idle next cycle.
- err_clr_i outside Error: ignored.
- Simultaneous push and pop when not full: both occur; count unchanged.
- FIFO pointers wrap modulo FifoDepth.
- rst_i asserted mid-message: all state cleared immediately (async); no done_o is generated.

Test Plan:
1. Single last beat, data=64'h0123_4567_89AB_CDEF, strb=8'h0F, last=1, msg_ready_i=1:
   - msg_valid_o next cycle, msg_mask_o=64'h0000_0000_FFFF_FFFF.
   - done_o pulse the cycle of pop.
   - byte_cnt_o=4.
   - kmac_ready_o=0 while in Flush.
2. Three beats (strb FF, FF, 03, last on third), msg_ready_i held 0:
   - Ready drops after 2 beats (FIFO full).
   - Release msg_ready_i → all 3 beats popped in order.
   - byte_cnt_o=18, single done_o on third pop.
3. Non-last beat with strb=8'h7F:
   - err_o=1, beat not visible, kmac_ready_o=0.
   - err_clr_i pulse → err_o=0, ready=1, byte_cnt_o=0.
4. Last beat with strb=8'h05 (non-contiguous), and separately strb=8'h00 → err_o=1 in both cases, no done_o.
5. Illegal beat while 1 legal beat is buffered → FIFO flushed, msg_valid_o=0, no done_o.
6. Reset asserted after 2 of 4 beats → all outputs to reset values immediately. A subsequent clean 1-beat message (strb=FF, last) completes with byte_cnt_o=8.
